lcd_bus_monitor: RTL and testbench
==================================

LCD_BUS_MONITOR -- requirements
Module: lcd_bus_monitor

Interface
REQ-001 SHALL have parameter MIN_E_HIGH, default 10, giving the minimum E-high width in clk cycles for a valid strobe.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on posedge clk.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port lcd_data, input, 4 bits: LCD D7..D4 nibble bus.
REQ-005 SHALL have port lcd_ctrl, input, 3 bits: {E, RS, RW'}, with RW'=0 meaning write.
REQ-006 SHALL have port rd_addr, input, 5 bits: shadow-RAM read address; 0-15 is line 1, 16-31 is line 2.
REQ-007 SHALL have port rd_data, output, 8 bits: combinational read of the shadow RAM at rd_addr.
REQ-008 SHALL have port byte_valid, output, 1 bit: one-cycle pulse when a complete byte is decoded.
REQ-009 SHALL have port byte_out, output, 8 bits: last decoded byte; byte_rs, output, 1 bit: its RS value.
REQ-010 SHALL have port cursor_pos, output, 5 bits: current DDRAM position, 0-31.
REQ-011 SHALL have ports display_on, cursor_on, blink_on, outputs, 1 bit each: last display-control flags.
REQ-012 SHALL have port init_done, output, 1 bit: the 4-bit power-on sequence has completed.
REQ-013 SHALL have port proto_err, output, 1 bit: one-cycle pulse on any protocol violation.

Function
REQ-014 SHALL register E each cycle and detect a strobe in the cycle where E=0 and registered E=1.
REQ-015 SHALL capture the nibble and RS from the last cycle E was high.
REQ-016 SHALL count E-high cycles and treat a strobe as invalid when the count is below MIN_E_HIGH: pulse proto_err and ignore the nibble.
REQ-017 SHALL treat a strobe with RW'=1 as invalid: pulse proto_err and ignore the nibble.
REQ-018 SHALL make all effects of a strobe (RAM, cursor, flags, byte_valid, proto_err) visible in the cycle after detection.
REQ-019 SHALL use FSM states INIT_A, INIT_B, INIT_C, INIT_D, NIB_HI and NIB_LO, with INIT_A as the reset state.
REQ-020 SHALL, in INIT_A through INIT_C, advance on a nibble 0x3 with RS=0.
REQ-021 SHALL, in INIT_D, advance to NIB_HI on a nibble 0x2 with RS=0 and set init_done=1.
REQ-022 SHALL, in any INIT state, pulse proto_err on any other nibble and return to INIT_A.
REQ-023 SHALL, in NIB_HI, store the high nibble and RS, then go to NIB_LO.
REQ-024 SHALL, in NIB_LO, assemble the byte, pulse byte_valid, update byte_out and byte_rs, execute the byte, and return to NIB_HI.
REQ-025 SHALL, when the RS of the low nibble differs from the stored RS, pulse proto_err, discard the byte, and return to NIB_HI.
REQ-026 SHALL, for RS=1, write the byte to RAM[cursor_pos] and then step cursor_pos by +1 (ID=1) or -1 (ID=0), wrapping 31->0 and 0->31.
REQ-027 SHALL decode RS=0 commands by highest set bit; 0x01 sets all 32 RAM entries to 0x20 in one cycle, sets cursor_pos=0 and sets ID=1.
REQ-028 SHALL, for 0x02-0x03, set cursor_pos=0 and leave RAM unchanged.
REQ-029 SHALL, for 0x04-0x07, set ID=bit1 and ignore bit0.
REQ-030 SHALL, for 0x08-0x0F, set display_on=bit2, cursor_on=bit1 and blink_on=bit0.
REQ-031 SHALL, for 0x10-0x1F with bit3=0, move cursor_pos right (bit2=1) or left (bit2=0) with wrap; with bit3=1 it SHALL have no effect.
REQ-032 SHALL, for 0x20-0x3F, pulse proto_err if bit4=1 (8-bit mode) and otherwise take no action.
REQ-033 SHALL ignore 0x40-0x7F (CGRAM address).
REQ-034 SHALL, for 0x80-0xFF with address a=byte[6:0], set cursor_pos=a for a=0x00-0x0F and cursor_pos=16+(a-0x40) for a=0x40-0x4F.
REQ-035 SHALL, for any other address a, pulse proto_err and leave cursor_pos unchanged.
REQ-036 SHALL, when a RAM write and a read of the same address occur in one cycle, return the old value on rd_data.

Reset
REQ-037 SHALL, while rst_n=0, immediately force state=INIT_A and set byte_valid=0, byte_out=0x00, byte_rs=0, cursor_pos=0, display_on=0, cursor_on=0, blink_on=0, init_done=0, proto_err=0, ID=1, E-high count=0, and all RAM entries=0x20.
REQ-038 SHALL, after reset is asserted mid-byte, discard any partial nibble; the next strobe is interpreted as INIT_A input.

Verification
REQ-039 SHALL be verified by this scenario: nibbles 3,3,3,2, then bytes 0x28, 0x06, 0x0C, 0x01 -> init_done=1, display_on=1, cursor_on=0, blink_on=0, cursor_pos=0, no proto_err.
REQ-040 SHALL be verified by this scenario: 0x80, then data 0x48, 0x69 -> RAM[0]=0x48, RAM[1]=0x69, cursor_pos=2, two byte_valid pulses with byte_rs=1.
REQ-041 SHALL be verified by this scenario: 0xCF, then data 0x41 -> RAM[31]=0x41 and cursor_pos=0; then 0x10 -> cursor_pos=31; then 0x14 -> cursor_pos=0.
REQ-042 SHALL be verified by this scenario: E high for 3 cycles, or RW'=1 strobe, or command 0x90 -> one proto_err pulse each, with FSM state and cursor_pos unchanged.
REQ-043 SHALL be verified by this scenario: high nibble sent, rst_n pulsed low, then nibble 0x3 -> all outputs at reset values, FSM advances to INIT_B, no byte_valid.
REQ-044 SHALL be verified by this scenario: RAM loaded with data, then 0x01 -> every rd_addr reads 0x20 and cursor_pos=0.

Source files
------------

// File: rtl/lcd_bus_monitor.sv
// Passive monitor for a 4-bit HD44780-style LCD bus.
// Decodes nibble strobes into bytes and mirrors DDRAM, cursor and display flags.
module lcd_bus_monitor #(
   parameter int MIN_E_HIGH = 10
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] lcd_data,
   input  logic [2:0] lcd_ctrl,
   input  logic [4:0] rd_addr,
   output logic [7:0] rd_data,
   output logic       byte_valid,
   output logic [7:0] byte_out,
   output logic       byte_rs,
   output logic [4:0] cursor_pos,
   output logic       display_on,
   output logic       cursor_on,
   output logic       blink_on,
   output logic       init_done,
   output logic       proto_err
);

   localparam int CW = $clog2(MIN_E_HIGH + 1) + 1;

   typedef enum logic [2:0] {
      INIT_A, INIT_B, INIT_C, INIT_D, NIB_HI, NIB_LO
   } state_t;

   state_t        state_q;
   logic          e_q;
   logic [3:0]    nib_q;
   logic          rs_q;
   logic          rw_q;
   logic [CW-1:0] cnt_q;
   logic [3:0]    hi_q;
   logic          hi_rs_q;
   logic          id_q;
   logic [7:0]    ram_q [32];

   logic       strobe;
   logic       ok;
   logic [7:0] byte_w;
   logic [6:0] addr_w;
   logic [4:0] cur_inc;
   logic [4:0] cur_dec;

   assign strobe  = !lcd_ctrl[2] && e_q;
   assign ok      = (cnt_q >= CW'(MIN_E_HIGH)) && !rw_q;
   assign byte_w  = {hi_q, nib_q};
   assign addr_w  = byte_w[6:0];
   assign cur_inc = cursor_pos + 5'd1;
   assign cur_dec = cursor_pos - 5'd1;
   assign rd_data = ram_q[rd_addr];

   // Nibble/RS/RW' track the last E-high cycle; count holds through the strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e_q   <= 1'b0;
         nib_q <= 4'h0;
         rs_q  <= 1'b0;
         rw_q  <= 1'b0;
         cnt_q <= '0;
      end else begin
         e_q <= lcd_ctrl[2];
         if (lcd_ctrl[2]) begin
            nib_q <= lcd_data;
            rs_q  <= lcd_ctrl[1];
            rw_q  <= lcd_ctrl[0];
            if (!e_q)
               cnt_q <= CW'(1);
            else if (cnt_q != '1)
               cnt_q <= cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= INIT_A;
         byte_valid <= 1'b0;
         byte_out   <= 8'h00;
         byte_rs    <= 1'b0;
         cursor_pos <= 5'd0;
         display_on <= 1'b0;
         cursor_on  <= 1'b0;
         blink_on   <= 1'b0;
         init_done  <= 1'b0;
         proto_err  <= 1'b0;
         hi_q       <= 4'h0;
         hi_rs_q    <= 1'b0;
         id_q       <= 1'b1;
         for (int i = 0; i < 32; i++) ram_q[i] <= 8'h20;
      end else begin
         byte_valid <= 1'b0;
         proto_err  <= 1'b0;
         if (strobe) begin
            if (!ok) begin
               proto_err <= 1'b1;
            end else begin
               unique case (state_q)
                  INIT_A, INIT_B, INIT_C: begin
                     if (nib_q == 4'h3 && !rs_q)
                        state_q <= (state_q == INIT_A) ? INIT_B :
                                   (state_q == INIT_B) ? INIT_C : INIT_D;
                     else begin
                        proto_err <= 1'b1;
                        state_q   <= INIT_A;
                     end
                  end
                  INIT_D: begin
                     if (nib_q == 4'h2 && !rs_q) begin
                        state_q   <= NIB_HI;
                        init_done <= 1'b1;
                     end else begin
                        proto_err <= 1'b1;
                        state_q   <= INIT_A;
                     end
                  end
                  NIB_HI: begin
                     hi_q    <= nib_q;
                     hi_rs_q <= rs_q;
                     state_q <= NIB_LO;
                  end
                  NIB_LO: begin
                     state_q <= NIB_HI;
                     if (rs_q != hi_rs_q) begin
                        proto_err <= 1'b1;
                     end else begin
                        byte_valid <= 1'b1;
                        byte_out   <= byte_w;
                        byte_rs    <= rs_q;
                        if (rs_q) begin
                           ram_q[cursor_pos] <= byte_w;
                           cursor_pos <= id_q ? cur_inc : cur_dec;
                        end else begin
                           unique case (1'b1)
                              byte_w[7]: begin
                                 if (addr_w[6:4] == 3'b000)
                                    cursor_pos <= {1'b0, addr_w[3:0]};
                                 else if (addr_w[6:4] == 3'b100)
                                    cursor_pos <= {1'b1, addr_w[3:0]};
                                 else
                                    proto_err <= 1'b1;
                              end
                              (byte_w[7:6] == 2'b01): ;
                              (byte_w[7:5] == 3'b001):
                                 proto_err <= byte_w[4];
                              (byte_w[7:4] == 4'b0001): begin
                                 if (!byte_w[3])
                                    cursor_pos <= byte_w[2] ? cur_inc : cur_dec;
                              end
                              (byte_w[7:3] == 5'b00001): begin
                                 display_on <= byte_w[2];
                                 cursor_on  <= byte_w[1];
                                 blink_on   <= byte_w[0];
                              end
                              (byte_w[7:2] == 6'b000001):
                                 id_q <= byte_w[1];
                              (byte_w[7:1] == 7'b0000001):
                                 cursor_pos <= 5'd0;
                              (byte_w == 8'h01): begin
                                 for (int i = 0; i < 32; i++) ram_q[i] <= 8'h20;
                                 cursor_pos <= 5'd0;
                                 id_q       <= 1'b1;
                              end
                              default: ;
                           endcase
                        end
                     end
                  end
                  default: state_q <= INIT_A;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_lcd_bus_monitor.sv
// Randomized bench for lcd_bus_monitor with a behavioural bus model.
// Directed scenarios pin the model with literal expectations.
module tb_lcd_bus_monitor;

   localparam int MIN = 10;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] lcd_data = 4'h0;
   logic [2:0] lcd_ctrl = 3'b000;
   logic [4:0] rd_addr = 5'd0;
   logic [7:0] rd_data;
   logic       byte_valid;
   logic [7:0] byte_out;
   logic       byte_rs;
   logic [4:0] cursor_pos;
   logic       display_on;
   logic       cursor_on;
   logic       blink_on;
   logic       init_done;
   logic       proto_err;

   always #5 clk = ~clk;

   lcd_bus_monitor #(.MIN_E_HIGH(MIN)) dut (
      .clk(clk), .rst_n(rst_n), .lcd_data(lcd_data), .lcd_ctrl(lcd_ctrl),
      .rd_addr(rd_addr), .rd_data(rd_data), .byte_valid(byte_valid),
      .byte_out(byte_out), .byte_rs(byte_rs), .cursor_pos(cursor_pos),
      .display_on(display_on), .cursor_on(cursor_on), .blink_on(blink_on),
      .init_done(init_done), .proto_err(proto_err)
   );

   int errors = 0;
   int checks = 0;
   int bv_seen = 0;
   int bvrs_seen = 0;
   int err_seen = 0;
   bit hold = 0;

   // Behavioural model: init progress 0..4, pending high nibble, RAM array.
   int       m_step;
   bit       m_hashi;
   bit [3:0] m_hi;
   bit       m_hrs;
   bit       m_id;
   bit [7:0] m_ram [32];
   int       m_cur;
   bit       exp_bv, exp_err, exp_brs, exp_disp, exp_curs, exp_blink, exp_init;
   bit [7:0] exp_bout;

   task automatic check(string name, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      check("cycle",
            {4'h0, rd_data, byte_valid, byte_out, byte_rs, cursor_pos,
             display_on, cursor_on, blink_on, init_done, proto_err},
            {4'h0, m_ram[rd_addr], exp_bv, exp_bout, exp_brs, 5'(m_cur),
             exp_disp, exp_curs, exp_blink, exp_init, exp_err});
      if (byte_valid) bv_seen++;
      if (byte_valid && byte_rs) bvrs_seen++;
      if (proto_err) err_seen++;
   end

   task automatic model_reset();
      m_step = 0; m_hashi = 0; m_hi = 0; m_hrs = 0; m_id = 1; m_cur = 0;
      for (int i = 0; i < 32; i++) m_ram[i] = 8'h20;
      exp_bv = 0; exp_err = 0; exp_brs = 0; exp_bout = 0;
      exp_disp = 0; exp_curs = 0; exp_blink = 0; exp_init = 0;
   endtask

   task automatic m_exec(int b, bit rs);
      int a;
      if (rs) begin
         m_ram[m_cur] = 8'(b);
         m_cur = (m_cur + (m_id ? 1 : 31)) % 32;
      end else if (b >= 128) begin
         a = b - 128;
         if (a < 16) m_cur = a;
         else if (a >= 64 && a < 80) m_cur = 16 + (a - 64);
         else exp_err = 1;
      end else if (b >= 64) begin
      end else if (b >= 32) begin
         if ((b & 16) != 0) exp_err = 1;
      end else if (b >= 16) begin
         if ((b & 8) == 0) m_cur = (m_cur + (((b & 4) != 0) ? 1 : 31)) % 32;
      end else if (b >= 8) begin
         exp_disp = (b & 4) != 0; exp_curs = (b & 2) != 0; exp_blink = (b & 1) != 0;
      end else if (b >= 4) begin
         m_id = (b & 2) != 0;
      end else if (b >= 2) begin
         m_cur = 0;
      end else if (b == 1) begin
         for (int i = 0; i < 32; i++) m_ram[i] = 8'h20;
         m_cur = 0; m_id = 1;
      end
   endtask

   task automatic m_apply(bit [3:0] nib, bit rs, bit rw, int k);
      int want;
      if (k < MIN || rw) begin
         exp_err = 1;
         return;
      end
      if (m_step < 4) begin
         want = (m_step == 3) ? 2 : 3;
         if (nib == 4'(want) && !rs) begin
            m_step++;
            if (m_step == 4) exp_init = 1;
         end else begin
            exp_err = 1; m_step = 0;
         end
      end else if (!m_hashi) begin
         m_hashi = 1; m_hi = nib; m_hrs = rs;
      end else begin
         m_hashi = 0;
         if (rs != m_hrs) exp_err = 1;
         else begin
            exp_bv = 1; exp_bout = {m_hi, nib}; exp_brs = rs;
            m_exec(int'({m_hi, nib}), rs);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
      if (!hold) rd_addr = 5'($urandom_range(0, 31));
   endtask

   task automatic strobe(bit [3:0] nib, bit rs, bit rw, int k);
      lcd_data = nib;
      lcd_ctrl = {1'b1, rs, rw};
      repeat (k) tick();
      lcd_ctrl[2] = 1'b0;
      tick();
      m_apply(nib, rs, rw, k);
      tick();
      exp_bv = 0; exp_err = 0;
      lcd_ctrl = 3'b000;
   endtask

   task automatic send_byte(bit [7:0] b, bit rs);
      strobe(b[7:4], rs, 0, MIN + int'($urandom_range(0, 3)));
      strobe(b[3:0], rs, 0, MIN + int'($urandom_range(0, 3)));
   endtask

   task automatic do_reset();
      tick();
      rst_n = 0;
      model_reset();
      tick(); tick();
      rst_n = 1;
      tick();
   endtask

   task automatic init_seq();
      strobe(4'h3, 0, 0, MIN);
      strobe(4'h3, 0, 0, MIN);
      strobe(4'h3, 0, 0, MIN);
      strobe(4'h2, 0, 0, MIN);
   endtask

   task automatic read_lit(string name, bit [4:0] a, bit [7:0] exp);
      hold = 1;
      rd_addr = a;
      #1;
      check(name, rd_data, exp);
      hold = 0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int e0, b0, r;
      bit [7:0] b;
      model_reset();
      do_reset();
      check("rst_cursor", cursor_pos, 0);
      read_lit("rst_ram", 5'd17, 8'h20);

      e0 = err_seen;
      init_seq();
      send_byte(8'h28, 0);
      send_byte(8'h06, 0);
      send_byte(8'h0C, 0);
      send_byte(8'h01, 0);
      check("s1_init", init_done, 1);
      check("s1_disp", {display_on, cursor_on, blink_on}, 3'b100);
      check("s1_cur", cursor_pos, 0);
      check("s1_noerr", err_seen - e0, 0);

      b0 = bvrs_seen;
      send_byte(8'h80, 0);
      send_byte(8'h48, 1);
      send_byte(8'h69, 1);
      read_lit("s2_ram0", 5'd0, 8'h48);
      read_lit("s2_ram1", 5'd1, 8'h69);
      check("s2_cur", cursor_pos, 2);
      check("s2_bvrs", bvrs_seen - b0, 2);

      send_byte(8'hCF, 0);
      check("s3_addr", cursor_pos, 31);
      send_byte(8'h41, 1);
      read_lit("s3_ram31", 5'd31, 8'h41);
      check("s3_wrap", cursor_pos, 0);
      send_byte(8'h10, 0);
      check("s3_left", cursor_pos, 31);
      send_byte(8'h14, 0);
      check("s3_right", cursor_pos, 0);

      e0 = err_seen;
      strobe(4'h8, 0, 0, 3);
      check("s4_short", err_seen - e0, 1);
      strobe(4'h8, 0, 1, MIN);
      check("s4_rw", err_seen - e0, 2);
      send_byte(8'h90, 0);
      check("s4_cmd", err_seen - e0, 3);
      check("s4_cur", cursor_pos, 0);
      send_byte(8'h55, 1);
      read_lit("s4_state", 5'd0, 8'h55);

      strobe(4'h4, 0, 0, MIN);
      b0 = bv_seen;
      do_reset();
      strobe(4'h3, 0, 0, MIN);
      check("s5_noinit", init_done, 0);
      check("s5_nobv", bv_seen - b0, 0);
      strobe(4'h3, 0, 0, MIN);
      strobe(4'h3, 0, 0, MIN);
      strobe(4'h2, 0, 0, MIN);
      check("s5_initb", init_done, 1);

      for (int i = 0; i < 6; i++) send_byte(8'($urandom_range(33, 126)), 1);
      send_byte(8'h01, 0);
      check("s6_cur", cursor_pos, 0);
      for (int i = 0; i < 32; i++) read_lit("s6_clr", 5'(i), 8'h20);

      for (int n = 0; n < 400; n++) begin
         r = int'($urandom_range(0, 99));
         if (r < 3) do_reset();
         else if (r < 10)
            strobe(4'($urandom), 1'($urandom), 1'($urandom),
                   int'($urandom_range(1, MIN + 2)));
         else if (r < 15)
            strobe(4'($urandom), 1'($urandom), 0, MIN);
         else if (m_step < 4) begin
            if (r < 90) strobe((m_step == 3) ? 4'h2 : 4'h3, 0, 0, MIN);
            else strobe(4'($urandom), 0, 0, MIN);
         end else begin
            b = 8'($urandom);
            if (r < 25) b = {4'b1100, b[3:0]};
            else if (r < 35) b = {3'b100, b[4:0]};
            else if (r < 50) b = {3'b000, b[4:0]};
            send_byte(b, (r >= 55) ? 1'b1 : 1'b0);
         end
      end

      repeat (3) tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
